// File: rtl/xm_pkg.sv
// rtl/xm_pkg.sv - shared FSM state and lane-select encodings for the memory interface
package xm_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] WORD_SEL = 2'b00;
    localparam logic [1:0] LO_SEL   = 2'b01;
    localparam logic [1:0] HI_SEL   = 2'b10;
    localparam logic [1:0] ILL_SEL  = 2'b11;

endpackage

// File: rtl/xm_lane_steer.sv
// rtl/xm_lane_steer.sv - byte-lane enables, write-data replication and read-data extraction
module xm_lane_steer
    import xm_pkg::*;
#(
    parameter int WORD = 16
) (
    input  logic [1:0]      cmd_sel_i,
    input  logic [WORD-1:0] cmd_wdata_i,
    output logic [1:0]      cmd_be_o,
    output logic [WORD-1:0] cmd_wdata_o,
    input  logic [1:0]      rsp_sel_i,
    input  logic [WORD-1:0] rsp_rdata_i,
    output logic [WORD-1:0] rsp_rdata_o
);

    always_comb begin
        cmd_be_o    = 2'b11;
        cmd_wdata_o = cmd_wdata_i;
        case (cmd_sel_i)
            LO_SEL, HI_SEL: begin
                cmd_be_o          = cmd_sel_i;
                // Byte writes drive the byte on both lanes; the enable picks the target.
                cmd_wdata_o       = '0;
                cmd_wdata_o[15:0] = {cmd_wdata_i[7:0], cmd_wdata_i[7:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_rdata_o = rsp_rdata_i;
        case (rsp_sel_i)
            LO_SEL: begin
                rsp_rdata_o      = '0;
                rsp_rdata_o[7:0] = rsp_rdata_i[7:0];
            end
            HI_SEL: begin
                rsp_rdata_o      = '0;
                rsp_rdata_o[7:0] = rsp_rdata_i[15:8];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/xm_mem_interface.sv
// rtl/xm_mem_interface.sv - single-outstanding memory bus access FSM with ack timeout
module xm_mem_interface
    import xm_pkg::*;
#(
    parameter int WORD    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            req_i,
    input  logic            wr_i,
    input  logic [WORD-2:0] addr_i,
    input  logic [1:0]      datSel_i,
    input  logic            badMem_i,
    input  logic [WORD-1:0] wdata_i,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [WORD-2:0] bus_addr_o,
    output logic [1:0]      bus_be_o,
    output logic [WORD-1:0] bus_wdata_o,
    input  logic            bus_ack_i,
    input  logic [WORD-1:0] bus_rdata_i,
    output logic [WORD-1:0] rdata_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            fault_o
);

    localparam logic [3:0] TMO = 4'(TIMEOUT);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            bus_req_q, bus_req_d;
    logic            we_q, we_d;
    logic [WORD-2:0] addr_q, addr_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      be_q, be_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [WORD-1:0] rdata_q, rdata_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;

    logic [1:0]      steer_be;
    logic [WORD-1:0] steer_wdata;
    logic [WORD-1:0] steer_rdata;
    logic [3:0]      cnt_inc;
    logic            req_legal;

    // Write-side steering works on the incoming request so the bus fields are captured already formatted.
    xm_lane_steer #(.WORD(WORD)) u_steer (
        .cmd_sel_i   (datSel_i),
        .cmd_wdata_i (wdata_i),
        .cmd_be_o    (steer_be),
        .cmd_wdata_o (steer_wdata),
        .rsp_sel_i   (sel_q),
        .rsp_rdata_i (bus_rdata_i),
        .rsp_rdata_o (steer_rdata)
    );

    assign cnt_inc   = cnt_q + 4'd1;
    assign req_legal = !badMem_i && (datSel_i != ILL_SEL);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_req_d = bus_req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (req_legal) begin
                        we_d      = wr_i;
                        addr_d    = addr_i;
                        sel_d     = datSel_i;
                        be_d      = steer_be;
                        wdata_d   = steer_wdata;
                        bus_req_d = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = ST_ISSUE;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                // Ack is checked first so an ack on the timeout cycle still completes.
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_RESP;
                    if (!we_q) rdata_d = steer_rdata;
                end else if (cnt_inc == TMO) begin
                    cnt_d     = cnt_inc;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            bus_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            sel_q     <= WORD_SEL;
            be_q      <= 2'b00;
            wdata_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_req_q <= bus_req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign fault_o     = fault_q;

endmodule

// File: tb/tb_xm_mem_interface.sv
// tb/tb_xm_mem_interface.sv - directed and randomized checks of xm_mem_interface against a transaction-level model
module tb_xm_mem_interface;

    localparam int WORD = 16;
    localparam int T    = 4;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        req_i, wr_i, badMem_i, bus_ack_i;
    logic [14:0] addr_i;
    logic [1:0]  datSel_i;
    logic [15:0] wdata_i, bus_rdata_i;
    logic        bus_req_o, bus_we_o, busy_o, done_o, fault_o;
    logic [14:0] bus_addr_o;
    logic [1:0]  bus_be_o;
    logic [15:0] bus_wdata_o, rdata_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_rdata;

    always #5 clk_i = ~clk_i;

    xm_mem_interface #(.WORD(WORD), .TIMEOUT(T)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .req_i       (req_i),
        .wr_i        (wr_i),
        .addr_i      (addr_i),
        .datSel_i    (datSel_i),
        .badMem_i    (badMem_i),
        .wdata_i     (wdata_i),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fault_o     (fault_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus_req"}, 32'(bus_req_o), 32'd0);
        chk({tag, "_bus_we"}, 32'(bus_we_o), 32'd0);
        chk({tag, "_bus_addr"}, 32'(bus_addr_o), 32'd0);
        chk({tag, "_bus_be"}, 32'(bus_be_o), 32'd0);
        chk({tag, "_bus_wdata"}, 32'(bus_wdata_o), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_fault"}, 32'(fault_o), 32'd0);
    endtask

    // d = number of bus-request cycles without ack before the ack cycle; d >= T means no ack at all.
    task automatic run_txn(input logic wr, input logic [14:0] addr, input logic [1:0] sel,
                           input logic bad, input logic [15:0] wdata, input int d,
                           input logic [15:0] rd, input logic noisy, input string tag);
        logic        legal;
        logic        e_req, e_busy, e_done, e_fault;
        logic [15:0] rdv;
        int          busy_cnt;
        legal    = !bad && (sel != 2'b11);
        busy_cnt = 0;
        req_i = 1'b1; wr_i = wr; addr_i = addr; datSel_i = sel; badMem_i = bad;
        wdata_i = wdata; bus_ack_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        req_i = 1'b0; wr_i = 1'($urandom); addr_i = 15'($urandom); wdata_i = 16'($urandom);
        for (int k = 1; k <= T + 3; k++) begin
            e_req   = legal && ((d < T) ? (k <= d + 1) : (k <= T));
            e_busy  = legal && ((d < T) ? (k <= d + 2) : (k <= T));
            e_done  = legal && (d < T) && (k == d + 2);
            e_fault = legal ? ((d >= T) && (k == T + 1)) : (k == 1);
            chk({tag, "_bus_req"}, 32'(bus_req_o), 32'(e_req));
            chk({tag, "_busy"}, 32'(busy_o), 32'(e_busy));
            chk({tag, "_done"}, 32'(done_o), 32'(e_done));
            chk({tag, "_fault"}, 32'(fault_o), 32'(e_fault));
            chk({tag, "_rdata"}, 32'(rdata_o), 32'(exp_rdata));
            if (busy_o) busy_cnt++;
            if (e_req) begin
                chk({tag, "_bus_we"}, 32'(bus_we_o), 32'(wr));
                chk({tag, "_bus_addr"}, 32'(bus_addr_o), 32'(addr));
                chk({tag, "_bus_be"}, 32'(bus_be_o), (sel == 2'b00) ? 32'd3 : 32'(sel));
                if (wr)
                    chk({tag, "_bus_wdata"}, 32'(bus_wdata_o),
                        (sel == 2'b00) ? 32'(wdata) : 32'(wdata[7:0]) * 32'h101);
            end
            rdv = (e_req && k == d + 1) ? rd : 16'($urandom);
            bus_rdata_i = rdv;
            if (e_req && k == d + 1) begin
                bus_ack_i = 1'b1;
                if (!wr)
                    exp_rdata = (sel == 2'b00) ? rdv :
                                (sel == 2'b01) ? (rdv % 16'd256) : (rdv / 16'd256);
            end else begin
                bus_ack_i = e_req ? 1'b0 : 1'($urandom);
            end
            req_i = noisy && legal && (k == 2);
            if (req_i) begin
                datSel_i = 2'($urandom_range(0, 2)); badMem_i = 1'b0;
            end
            @(posedge clk_i); @(negedge clk_i);
        end
        bus_ack_i = 1'b0;
        req_i     = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(busy_cnt),
            legal ? ((d < T) ? 32'(d + 2) : 32'(T)) : 32'd0);
    endtask

    initial begin
        exp_rdata = 16'h0;
        req_i = 1'b0; wr_i = 1'b0; addr_i = '0; datSel_i = 2'b00; badMem_i = 1'b0;
        wdata_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        arst_i = 1'b1;
        #2;
        chk_reset_outputs("por");
        @(negedge clk_i); @(negedge clk_i);
        arst_i = 1'b0;

        run_txn(1'b0, 15'h0010, 2'b00, 1'b0, 16'h0000, 0, 16'hBEEF, 1'b0, "word_rd");
        run_txn(1'b0, 15'h0123, 2'b10, 1'b0, 16'h0000, 3, 16'h12AB, 1'b0, "hi_rd");
        run_txn(1'b1, 15'h0456, 2'b01, 1'b0, 16'h00C3, 1, 16'h5555, 1'b0, "lo_wr");
        run_txn(1'b0, 15'h0222, 2'b00, 1'b1, 16'h0000, 0, 16'h7777, 1'b0, "bad_mem");
        run_txn(1'b1, 15'h0333, 2'b11, 1'b0, 16'hAAAA, 0, 16'h7777, 1'b0, "ill_sel");
        run_txn(1'b0, 15'h0444, 2'b00, 1'b0, 16'h0000, 99, 16'h9999, 1'b0, "timeout");
        run_txn(1'b1, 15'h0555, 2'b00, 1'b0, 16'hA5F0, T - 1, 16'h0, 1'b0, "ack_at_tmo");
        run_txn(1'b0, 15'h0666, 2'b01, 1'b0, 16'h0000, 2, 16'h3C5A, 1'b1, "busy_req");

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), 15'($urandom), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), 16'($urandom), $urandom_range(0, T + 1),
                    16'($urandom), 1'($urandom), "rand");
        end

        // Reset while waiting, then a stray ack after release.
        run_txn(1'b0, 15'h0777, 2'b00, 1'b0, 16'h0000, 0, 16'h4321, 1'b0, "pre_rst");
        req_i = 1'b1; wr_i = 1'b1; addr_i = 15'h7ABC; datSel_i = 2'b10; badMem_i = 1'b0;
        wdata_i = 16'h9E3C;
        @(posedge clk_i); @(negedge clk_i);
        req_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        chk("rst_pre_busy", 32'(busy_o), 32'd1);
        #1 arst_i = 1'b1;
        #1 chk_reset_outputs("rst_wait");
        @(negedge clk_i);
        arst_i = 1'b0;
        exp_rdata = 16'h0;
        bus_ack_i = 1'b1;
        bus_rdata_i = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); @(negedge clk_i);
            chk_reset_outputs("late_ack");
        end
        bus_ack_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/xm_mem_interface.md
XM_MEM_INTERFACE -- requirements
Module: xm_mem_interface

Interface
REQ-001 Parameter WORD, default 16: datapath word width in bits.
REQ-002 Parameter TIMEOUT, default 15: maximum number of cycles to wait for bus_ack_i before a fault is declared; range 1..15.
REQ-003 clk_i  in  1  single system clock; all state changes on rising edge.
REQ-004 arst_i  in  1  reset, asynchronous and active-high.
REQ-005 req_i  in  1  start-access strobe from the controller; sampled in IDLE only.
REQ-006 wr_i  in  1  1 = write, 0 = read; sampled with req_i.
REQ-007 addr_i  in  WORD-1  word address, bits [15:1] of the byte address (datapath MAR).
REQ-008 datSel_i  in  2  lane select: 00 = word, 01 = low byte, 10 = high byte, 11 = illegal.
REQ-009 badMem_i  in  1  misaligned or illegal address flag from the address decoder.
REQ-010 wdata_i  in  WORD  write data (datapath OMDR); byte writes use bits [7:0].
REQ-011 bus_req_o  out  1  memory bus request; held until ack.
REQ-012 bus_we_o, bus_addr_o[WORD-2:0], bus_be_o[1:0], bus_wdata_o[WORD-1:0]  out  memory bus command fields.
REQ-013 bus_ack_i  in  1  memory bus completion; bus_rdata_i  in  WORD  read data, valid with ack.
REQ-014 rdata_o  out  WORD  read result delivered to the datapath memory input.
REQ-015 busy_o, done_o, fault_o  out  1 each  status to the controller; done_o and fault_o are single-cycle pulses.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-017 In IDLE, if req_i=1 and (badMem_i=1 or datSel_i=11), the block SHALL pulse fault_o on the next cycle, issue no bus cycle, and remain in IDLE.
REQ-018 In IDLE, a legal req_i SHALL register wr_i, addr_i, datSel_i and wdata_i, then move to ISSUE.
REQ-019 In ISSUE and WAIT, the block SHALL assert bus_req_o with the registered command; all command fields SHALL remain stable until ack.
REQ-020 bus_be_o SHALL be 11 for word, 01 for low byte, and 10 for high byte.
REQ-021 On a byte write, bus_wdata_o SHALL be {wdata[7:0], wdata[7:0]}; on a word write, bus_wdata_o SHALL equal wdata.
REQ-022 On a read ack, rdata_o SHALL latch bus_rdata_i for a word access, the zero-extended low byte for a low-byte access, or the zero-extended high byte for a high-byte access.
REQ-023 On bus_ack_i in ISSUE or WAIT, the block SHALL drop bus_req_o on the next edge, enter RESP, and pulse done_o for exactly one cycle in RESP.
REQ-024 RESP SHALL return unconditionally to IDLE; the minimum req-to-done latency is 2 cycles (ack in ISSUE).
REQ-025 ISSUE SHALL go to WAIT when there is no ack; a 4-bit wait counter SHALL clear on entering ISSUE and increment each cycle without ack.
REQ-026 When the counter reaches TIMEOUT without ack, the block SHALL drop bus_req_o, pulse fault_o, and return to IDLE; rdata_o SHALL be unchanged.
REQ-027 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL take priority: the block SHALL complete normally.
REQ-028 busy_o SHALL be 1 in every state except IDLE; req_i while busy SHALL be ignored, not queued.
REQ-029 bus_ack_i in IDLE or RESP SHALL be ignored.
REQ-030 A write access SHALL leave rdata_o unchanged.

Reset
REQ-031 On arst_i: state = IDLE; counter = 0; bus_req_o, bus_we_o, busy_o, done_o and fault_o = 0; bus_addr_o, bus_be_o, bus_wdata_o and rdata_o = 0.
REQ-032 Reset during ISSUE or WAIT SHALL abandon the access with no done_o or fault_o pulse; a late ack after reset release SHALL be ignored per REQ-029.

Structure
REQ-033 The FSM state enum and the lane-select encodings (WORD_SEL, LO_SEL, HI_SEL) SHALL live in shared package xm_pkg, used also by the datapath and controller.
REQ-034 Lane steering (REQ-020 to REQ-022) SHALL be one combinational sub-module, xm_lane_steer; the FSM and counter SHALL stay in the top module.

Verification
REQ-035 Word read at addr 0x0010 with ack in ISSUE returning 0xBEEF -> bus_be=11, done_o pulses 2 cycles after req, rdata_o=0xBEEF.
REQ-036 High-byte read with bus_rdata 0x12AB and ack after 3 wait cycles -> rdata_o=0x0012, busy_o high for 5 cycles.
REQ-037 Low-byte write with wdata 0x00C3 -> bus_wdata=0xC3C3, bus_be=01, bus_we=1, rdata_o unchanged.
REQ-038 Request with badMem_i=1 -> fault_o pulse, bus_req_o never asserted; then, with no ack and TIMEOUT=4 -> fault_o after 4 wait cycles, bus_req_o low, FSM in IDLE.
REQ-039 Ack coincident with the timeout cycle -> done_o, not fault_o; arst_i in WAIT followed by a late ack -> no pulses, all outputs at reset values.
